// File: rtl/move_buffer_pkg.sv
// rtl/move_buffer_pkg.sv - shared constants and types for the move buffer
package move_buffer_pkg;

  localparam logic [7:0] MSG_COORD_MOVE = 8'h01;
  localparam logic [7:0] MSG_CLK_DIV    = 8'h03;
  localparam logic [7:0] MSG_MICROSTEP  = 8'h04;

  localparam int HDR_MSB = 63;
  localparam int HDR_LSB = 56;

  localparam int MOVE_W = 64;

  typedef enum logic [1:0] {
    P_IDLE       = 2'd0,
    P_GET_DUR    = 2'd1,
    P_GET_INC    = 2'd2,
    P_GET_INCINC = 2'd3
  } parse_state_e;

  // Queued move; dir sits at the top, incrementincrement at bit 0.
  typedef struct packed {
    logic              dir;
    logic [MOVE_W-1:0] duration;
    logic [MOVE_W-1:0] increment;
    logic [MOVE_W-1:0] incrementincrement;
  } move_entry_t;

  // Entry width and field offsets for an arbitrary field width w.
  function automatic int entry_w(input int w);
    return 1 + 3 * w;
  endfunction

  function automatic int off_dir(input int w);
    return 3 * w;
  endfunction

  function automatic int off_dur(input int w);
    return 2 * w;
  endfunction

  function automatic int off_inc(input int w);
    return w;
  endfunction

  // True for headers owned by some decoder on the SPI stream.
  function automatic logic is_known_msg(input logic [7:0] hdr);
    return (hdr == MSG_COORD_MOVE) || (hdr == MSG_CLK_DIV) || (hdr == MSG_MICROSTEP);
  endfunction

endpackage

// File: rtl/move_buffer_sync_fifo.sv
// rtl/move_buffer_sync_fifo.sv - show-ahead synchronous FIFO with wrap-bit pointers
module move_buffer_sync_fifo #(
  parameter int WIDTH = 193,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[IDX_W] != rptr_q[IDX_W]) &&
                   (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);

  // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;

  assign count_o = wptr_q - rptr_q;
  // Outputs read zero when nothing is queued so the head never shows stale data.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[IDX_W-1:0]];

  // Next pointer values; clear overrides any push or pop on the same edge.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_W'(1);
      if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage; no reset needed since empty slots are never presented.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      mem_q[wptr_q[IDX_W-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/move_buffer.sv
// rtl/move_buffer.sv - coordinated-move parser and queue for the step executor
module move_buffer
  import move_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 64
) (
  input  logic                    CLK,
  input  logic                    resetn,
  input  logic                    clear,
  input  logic                    word_received,
  input  logic [WORD_W-1:0]       word_data,
  output logic                    move_valid,
  input  logic                    move_ready,
  output logic                    move_dir,
  output logic [WORD_W-1:0]       move_duration,
  output logic [WORD_W-1:0]       move_increment,
  output logic [WORD_W-1:0]       move_incrementincrement,
  output logic [$clog2(DEPTH):0]  buffer_count,
  output logic                    buffer_full,
  output logic                    overflow
);

  localparam int ENTRY_W = entry_w(WORD_W);
  localparam int O_DIR   = off_dir(WORD_W);
  localparam int O_DUR   = off_dur(WORD_W);
  localparam int O_INC   = off_inc(WORD_W);

  parse_state_e      state_q, state_d;
  logic              dir_q, dir_d;
  logic [WORD_W-1:0] dur_q, dur_d;
  logic [WORD_W-1:0] inc_q, inc_d;
  logic              word_prev_q;
  logic              word_accept;
  logic              push;
  logic              overflow_q, overflow_d;

  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_drop;

  // Only the rising edge of the level strobe consumes a word.
  assign word_accept = word_received && !word_prev_q;

  // The final payload word goes straight into the entry without a holding register.
  assign push_data = {dir_q, dur_q, inc_q, word_data};

  // Parser next state: one accepted word per transition, clear returns to IDLE.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    dur_d   = dur_q;
    inc_d   = inc_q;
    push    = 1'b0;
    if (clear) begin
      state_d = P_IDLE;
    end else if (word_accept) begin
      case (state_q)
        P_IDLE: begin
          if (word_data[HDR_MSB:HDR_LSB] == MSG_COORD_MOVE) begin
            dir_d   = word_data[0];
            state_d = P_GET_DUR;
          end
        end
        P_GET_DUR: begin
          dur_d   = word_data;
          state_d = P_GET_INC;
        end
        P_GET_INC: begin
          inc_d   = word_data;
          state_d = P_GET_INCINC;
        end
        P_GET_INCINC: begin
          push    = 1'b1;
          state_d = P_IDLE;
        end
        default: state_d = P_IDLE;
      endcase
    end
  end

  // Parser registers and strobe history.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= P_IDLE;
      dir_q       <= 1'b0;
      dur_q       <= '0;
      inc_q       <= '0;
      word_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      dur_q       <= dur_d;
      inc_q       <= inc_d;
      word_prev_q <= word_received;
    end
  end

  // Sticky drop flag, cleared only by clear or reset.
  always_comb begin
    overflow_d = overflow_q;
    if (clear) begin
      overflow_d = 1'b0;
    end else if (fifo_drop) begin
      overflow_d = 1'b1;
    end
  end

  // Overflow register.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  move_buffer_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (resetn),
    .clear_i     (clear),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (move_ready),
    .rdata_o     (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop),
    .count_o     (buffer_count)
  );

  assign move_valid              = !fifo_empty;
  assign buffer_full             = fifo_full;
  assign overflow                = overflow_q;
  assign move_dir                = head[O_DIR];
  assign move_duration           = head[O_DUR +: WORD_W];
  assign move_increment          = head[O_INC +: WORD_W];
  assign move_incrementincrement = head[0 +: WORD_W];

endmodule
